// File: rtl/control_pkg.sv
// Shared encodings for the main instruction decoder: opcode and ALUop constants
// plus the packed control word carried from decode to the output register.
package control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       jump;
      logic       beq;
      logic       bne;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_write;
   } ctrl_word_t;

endpackage

// File: rtl/control_if.sv
// Opcode in, registered control word out; master drives Instruction, slave is the decoder.
interface control_if;

   logic [5:0] Instruction;
   logic       RegDst;
   logic       Jump;
   logic       BEQ;
   logic       BNE;
   logic       MemRead;
   logic       MemToReg;
   logic       MemWrite;
   logic [1:0] ALUop;
   logic       ALUsrc;
   logic       RegWrite;
   logic       Illegal;

   modport master (
      output Instruction,
      input  RegDst, Jump, BEQ, BNE, MemRead, MemToReg, MemWrite, ALUop, ALUsrc, RegWrite, Illegal
   );

   modport slave (
      input  Instruction,
      output RegDst, Jump, BEQ, BNE, MemRead, MemToReg, MemWrite, ALUop, ALUsrc, RegWrite, Illegal
   );

endinterface

// File: rtl/control_decode.sv
// Purely combinational opcode -> control word map; unsupported opcodes yield a NOP
// control word with illegal raised.
module control_decode
   import control_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_word_t ctrl,
   output logic       illegal
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_BEQ: begin
            ctrl.beq    = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_BNE: begin
            ctrl.bne    = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_J: begin
            ctrl.jump   = 1'b1;
            ctrl.alu_op = ALU_ADD;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control.sv
// Main control unit: decodes the opcode sampled on each rising edge and presents
// the registered control word one cycle later; synchronous reset clears everything.
module control
   import control_pkg::*;
(
   input  logic clk,
   input  logic rst,
   control_if.slave bus
);

   ctrl_word_t ctrl_d;
   ctrl_word_t ctrl_q;
   logic       illegal_d;
   logic       illegal_q;

   control_decode u_decode (
      .opcode  (bus.Instruction),
      .ctrl    (ctrl_d),
      .illegal (illegal_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.RegDst   = ctrl_q.reg_dst;
   assign bus.Jump     = ctrl_q.jump;
   assign bus.BEQ      = ctrl_q.beq;
   assign bus.BNE      = ctrl_q.bne;
   assign bus.MemRead  = ctrl_q.mem_read;
   assign bus.MemToReg = ctrl_q.mem_to_reg;
   assign bus.MemWrite = ctrl_q.mem_write;
   assign bus.ALUop    = ctrl_q.alu_op;
   assign bus.ALUsrc   = ctrl_q.alu_src;
   assign bus.RegWrite = ctrl_q.reg_write;
   assign bus.Illegal  = illegal_q;

endmodule

// File: tb/tb_control.sv
// Directed bench for the control unit; observed outputs are packed as
// {RegDst,Jump,BEQ,BNE,MemRead,MemToReg,MemWrite,ALUop[1:0],ALUsrc,RegWrite,Illegal}.
module tb_control;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   control_if bus ();

   control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   //                         RJBBMMMAA SWI
   localparam logic [11:0] V_ZERO = 12'b0000000_00_000;
   localparam logic [11:0] V_RTYP = 12'b1000000_10_010;
   localparam logic [11:0] V_LW   = 12'b0000110_00_110;
   localparam logic [11:0] V_SW   = 12'b0000001_00_100;
   localparam logic [11:0] V_BEQ  = 12'b0010000_01_000;
   localparam logic [11:0] V_BNE  = 12'b0001000_01_000;
   localparam logic [11:0] V_J    = 12'b0100000_00_000;
   localparam logic [11:0] V_ILL  = 12'b0000000_00_001;

   function automatic logic [11:0] observed();
      return {bus.RegDst, bus.Jump, bus.BEQ, bus.BNE, bus.MemRead, bus.MemToReg,
              bus.MemWrite, bus.ALUop, bus.ALUsrc, bus.RegWrite, bus.Illegal};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [11:0] obs;
      rst = 1'b1;
      bus.Instruction = 6'b000000;
      step();
      step();
      obs = observed();
      vectors++;
      if (obs !== V_ZERO) begin
         errors++;
         $display("FAIL reset_state got %b want %b", obs, V_ZERO);
      end
   endtask

   task automatic test_sequence();
      logic [5:0]  ops  [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};
      logic [11:0] exps [6] = '{V_RTYP, V_LW, V_SW, V_BEQ, V_BNE, V_J};
      logic [11:0] obs;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.Instruction = ops[i];
         step();
         obs = observed();
         vectors++;
         if (obs !== exps[i]) begin
            errors++;
            $display("FAIL seq_op_%b got %b want %b", ops[i], obs, exps[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [11:0] obs;
      bus.Instruction = 6'b111111;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_ILL) begin
         errors++;
         $display("FAIL illegal_111111 got %b want %b", obs, V_ILL);
      end
      bus.Instruction = 6'b101011;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_SW) begin
         errors++;
         $display("FAIL illegal_then_sw got %b want %b", obs, V_SW);
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] obs;
      bus.Instruction = 6'b101011;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_SW) begin
         errors++;
         $display("FAIL pre_reset_sw got %b want %b", obs, V_SW);
      end
      rst = 1'b1;
      bus.Instruction = 6'b100011;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_ZERO) begin
         errors++;
         $display("FAIL reset_over_lw got %b want %b", obs, V_ZERO);
      end
      rst = 1'b0;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_LW) begin
         errors++;
         $display("FAIL lw_after_reset got %b want %b", obs, V_LW);
      end
   endtask

   task automatic test_glitch();
      logic [11:0] obs;
      bus.Instruction = 6'b000000;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_RTYP) begin
         errors++;
         $display("FAIL glitch_base got %b want %b", obs, V_RTYP);
      end
      bus.Instruction = 6'b111111;
      #2;
      obs = observed();
      vectors++;
      if (obs !== V_RTYP) begin
         errors++;
         $display("FAIL glitch_mid1 got %b want %b", obs, V_RTYP);
      end
      bus.Instruction = 6'b100011;
      #2;
      obs = observed();
      vectors++;
      if (obs !== V_RTYP) begin
         errors++;
         $display("FAIL glitch_mid2 got %b want %b", obs, V_RTYP);
      end
      bus.Instruction = 6'b000101;
      step();
      obs = observed();
      vectors++;
      if (obs !== V_BNE) begin
         errors++;
         $display("FAIL glitch_final got %b want %b", obs, V_BNE);
      end
   endtask

   task automatic test_sweep();
      logic [11:0] obs;
      logic [11:0] want;
      int          legal = 0;
      for (int i = 0; i < 64; i++) begin
         bus.Instruction = 6'(i);
         case (6'(i))
            6'b000000: want = V_RTYP;
            6'b100011: want = V_LW;
            6'b101011: want = V_SW;
            6'b000100: want = V_BEQ;
            6'b000101: want = V_BNE;
            6'b000010: want = V_J;
            default:   want = V_ILL;
         endcase
         step();
         obs = observed();
         if (obs[0] === 1'b0) legal++;
         vectors++;
         if (obs !== want) begin
            errors++;
            $display("FAIL sweep_%0d got %b want %b", i, obs, want);
         end
         vectors++;
         if ((32'(bus.Jump) + 32'(bus.BEQ) + 32'(bus.BNE)) > 1 || (bus.MemRead && bus.MemWrite)
             || (^obs === 1'bx)) begin
            errors++;
            $display("FAIL sweep_exclusive_%0d got %b want flow/mem exclusive, no X", i, obs);
         end
      end
      vectors++;
      if (legal != 6) begin
         errors++;
         $display("FAIL sweep_legal_count got %0d want 6", legal);
      end
   endtask

   initial begin
      bus.Instruction = 6'b000000;
      test_reset();
      test_sequence();
      test_illegal();
      test_reset_mid();
      test_glitch();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 The block SHALL have no parameters; opcode and ALUop encodings SHALL be fixed constants.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Instruction  input  6  opcode field, instr[31:26].
REQ-006 RegDst  output  1  1 = write register from rd, 0 = from rt.
REQ-007 Jump  output  1  unconditional jump.
REQ-008 BEQ  output  1  branch if equal.
REQ-009 BNE  output  1  branch if not equal.
REQ-010 MemRead  output  1  data-memory read enable.
REQ-011 MemToReg  output  1  1 = writeback from memory, 0 = from ALU.
REQ-012 MemWrite  output  1  data-memory write enable.
REQ-013 ALUop  output  2  00 add, 01 subtract/compare, 10 R-type funct decode, 11 unused.
REQ-014 ALUsrc  output  1  1 = ALU operand B is the sign-extended immediate.
REQ-015 RegWrite  output  1  register-file write enable.
REQ-016 Illegal  output  1  opcode not in the supported set.

Function
REQ-017 All outputs SHALL be registered and valid one clk cycle after Instruction is sampled on a rising edge.
REQ-018 Only the opcode sampled at the most recent edge SHALL determine the outputs; changes on Instruction between edges SHALL have no effect.
REQ-019 Opcode 000000 (R-type) SHALL decode as follows:
- RegDst=1, RegWrite=1, ALUop=10
- all other controls 0.
REQ-020 Opcode 100011 (lw) SHALL decode as follows:
- ALUsrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUop=00
- all other controls 0.
REQ-021 Opcode 101011 (sw) SHALL decode as follows:
- ALUsrc=1, MemWrite=1, ALUop=00
- all other controls 0, including RegWrite, MemRead and RegDst.
REQ-022 Opcode 000100 (beq) SHALL decode as BEQ=1, ALUop=01, with all other controls 0.
REQ-023 Opcode 000101 (bne) SHALL decode as BNE=1, ALUop=01, with all other controls 0.
REQ-024 Opcode 000010 (j) SHALL decode as Jump=1, ALUop=00, with all other controls 0.
REQ-025 Any other opcode SHALL drive every control 0 and ALUop=00 (a NOP: no register write, no memory access, no branch or jump) and set Illegal=1.
REQ-026 Illegal SHALL be 0 for all six supported opcodes.
REQ-027 At most one of Jump, BEQ and BNE SHALL be 1 in any cycle.
REQ-028 MemRead and MemWrite SHALL never both be 1.
REQ-029 Outputs SHALL never be X/Z after the first reset.

Reset
REQ-030 While rst=1 at a rising edge, every output SHALL become 0, including ALUop=00 and Illegal=0.
REQ-031 Reset SHALL take priority over decode; an opcode presented during a reset cycle SHALL be discarded.
REQ-032 The first decode after reset SHALL appear one cycle after the first edge with rst=0.

Structure
REQ-033 A shared package control_pkg SHALL hold:
- opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J
- ALUop constants ALU_ADD, ALU_SUB, ALU_FUNCT
- a packed control-word struct.
REQ-034 A combinational sub-module control_decode SHALL map opcode to the control word plus Illegal; control SHALL register its output.

Verification
REQ-035 Hold rst=1 for 2 cycles with Instruction=000000 -> all outputs 0 and Illegal=0.
REQ-036 Apply the sequence 000000, 100011, 101011, 000100, 000101, 000010, one per cycle; each result appears one cycle later:
- R-type: RegDst=1, RegWrite=1, ALUop=10
- lw: ALUsrc=1, MemRead=1, MemToReg=1, RegWrite=1
- sw: ALUsrc=1, MemWrite=1
- beq: BEQ=1, ALUop=01
- bne: BNE=1, ALUop=01
- j: Jump=1.
REQ-037 Instruction=111111 -> all controls 0 and Illegal=1; then 101011 -> sw decode and Illegal=0.
REQ-038 Assert rst while sw is decoded -> outputs 0 on the next edge; deassert with 100011 -> lw decode one cycle later.
REQ-039 Toggle Instruction mid-cycle between edges -> outputs unchanged until the next edge.
REQ-040 Sweep all 64 opcodes -> exactly 6 give Illegal=0, and REQ-027 and REQ-028 hold throughout.
